// File: rtl/fp8_add_arbiter.sv
// Four-requester arbiter that time-shares one external combinational fp8 adder.
// Define FP8_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority; default is round-robin.
module fp8_add_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic [3:0]  gnt,
  output logic        busy,
  output logic [7:0]  add_x,
  output logic [7:0]  add_y,
  input  logic [7:0]  add_z,
  output logic [7:0]  res,
  output logic [3:0]  res_vld,
  output logic [7:0]  op_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic [1:0]  ptr_q;
  logic [1:0]  win_q;
  logic [1:0]  win_d;
  logic [3:0]  gnt_q;
  logic [3:0]  vld_q;
  logic        busy_q;
  logic [7:0]  add_x_q;
  logic [7:0]  add_y_q;
  logic [7:0]  res_q;
  logic [7:0]  cnt_q;
  logic        found_s;
  logic [1:0]  idx_s;

  // Search upward from ptr_q (held at 0 in the fixed-priority build) for the first requester.
  always_comb begin
    win_d   = 2'd0;
    found_s = 1'b0;
    idx_s   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx_s = ptr_q + 2'(i);
      if (!found_s && req[idx_s]) begin
        win_d   = idx_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      win_q   <= 2'd0;
      gnt_q   <= 4'd0;
      vld_q   <= 4'd0;
      busy_q  <= 1'b0;
      add_x_q <= 8'd0;
      add_y_q <= 8'd0;
      res_q   <= 8'd0;
      cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req != 4'd0) begin
            win_q   <= win_d;
            add_x_q <= opa[{win_d, 3'b000} +: 8];
            add_y_q <= opb[{win_d, 3'b000} +: 8];
            gnt_q   <= 4'b0001 << win_d;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          res_q   <= add_z;
          gnt_q   <= 4'd0;
          vld_q   <= 4'b0001 << win_q;
          state_q <= RESP;
        end
        RESP: begin
          vld_q   <= 4'd0;
          busy_q  <= 1'b0;
          cnt_q   <= cnt_q + 8'd1;
`ifdef FP8_ARB_FIXED_PRIO_EN
          ptr_q   <= 2'd0;
`else
          ptr_q   <= win_q + 2'd1;
`endif
          state_q <= IDLE;
        end
        default: begin
          gnt_q   <= 4'd0;
          vld_q   <= 4'd0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // A reset landing in RESP aborts the operation, so the strobe is suppressed that cycle.
  assign res_vld = vld_q & {4{~rst}};
  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign add_x   = add_x_q;
  assign add_y   = add_y_q;
  assign res     = res_q;
  assign op_cnt  = cnt_q;

endmodule

// File: tb/tb_fp8_add_arbiter.sv
// Randomized scoreboard bench for fp8_add_arbiter with a timeline-based reference model.
module tb_fp8_add_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [3:0]  gnt;
  logic        busy;
  logic [7:0]  add_x;
  logic [7:0]  add_y;
  logic [7:0]  add_z;
  logic [7:0]  res;
  logic [3:0]  res_vld;
  logic [7:0]  op_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         w;
    logic [7:0] r;
  } exp_t;
  exp_t sb_q[$];

  fp8_add_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .opa(opa), .opb(opb),
    .gnt(gnt), .busy(busy), .add_x(add_x), .add_y(add_y), .add_z(add_z),
    .res(res), .res_vld(res_vld), .op_cnt(op_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value of an fp8 {s, e[2:0], f[3:0]} (bias 3) in units of 2^-6.
  function automatic int fp8_val(input logic [7:0] v);
    int m;
    if (v[6:4] == 3'd0) m = int'(v[3:0]);
    else m = (16 + int'(v[3:0])) << (int'(v[6:4]) - 1);
    return v[7] ? -m : m;
  endfunction

  function automatic logic [7:0] fp8_add(input logic [7:0] a, input logic [7:0] b);
    int s, mag, e;
    logic sg;
    logic [3:0] f;
    s   = fp8_val(a) + fp8_val(b);
    sg  = (s < 0);
    mag = sg ? -s : s;
    if (mag < 16) begin
      f = 4'(mag);
      return {sg, 3'd0, f};
    end
    e = 1;
    while (((mag >> (e - 1)) >= 32) && (e < 8)) e++;
    if (e > 7) return {sg, 7'h7F};
    f = 4'((mag >> (e - 1)) - 16);
    return {sg, 3'(e), f};
  endfunction

  assign add_z = fp8_add(add_x, add_y);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: one operation in flight, described by its issue edge.
  int         cyc = 0;
  bit         started = 0;
  bit         have_op = 0;
  int         op_k, op_w;
  logic [7:0] op_res;
  int         m_ptr = 0;
  int         m_cnt = 0;
  logic [3:0] e_gnt = '0, e_vld = '0;
  logic       e_busy = 1'b0;
  logic [7:0] e_x = '0, e_y = '0, e_res = '0;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        have_op = 0; m_ptr = 0; m_cnt = 0;
        e_x = '0; e_y = '0; e_res = '0;
        sb_q.delete();
        started = 1;
      end else if (have_op) begin
        if (cyc == op_k + 1) e_res = op_res;
        if (cyc == op_k + 2) begin
`ifdef FP8_ARB_FIXED_PRIO_EN
          m_ptr = 0;
`else
          m_ptr = (op_w + 1) % 4;
`endif
          m_cnt = (m_cnt + 1) % 256;
          have_op = 0;
        end
      end else if (req != 4'd0) begin
        exp_t e;
        op_w    = pick(req, m_ptr);
        op_k    = cyc;
        e_x     = opa[op_w*8 +: 8];
        e_y     = opb[op_w*8 +: 8];
        op_res  = fp8_add(e_x, e_y);
        e.w     = op_w;
        e.r     = op_res;
        sb_q.push_back(e);
        have_op = 1;
      end
      e_gnt  = (have_op && cyc == op_k)     ? (4'b0001 << op_w) : 4'd0;
      e_vld  = (have_op && cyc == op_k + 1) ? (4'b0001 << op_w) : 4'd0;
      e_busy = have_op;
      cyc++;
    end
  end

  // Monitor: per-cycle output checks plus scoreboard pop on each result strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("res_vld", 32'(res_vld), 32'(e_vld & {4{~rst}}));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("add_x", 32'(add_x), 32'(e_x));
        chk("add_y", 32'(add_y), 32'(e_y));
        chk("res", 32'(res), 32'(e_res));
        chk("op_cnt", 32'(op_cnt), 32'(m_cnt));
        if (res_vld != 4'd0) begin
          if (sb_q.size() == 0) begin
            chk("sb_unexpected_vld", 32'(res_vld), 32'd0);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_winner", 32'(res_vld), 32'(4'b0001 << e.w));
            chk("sb_result", 32'(res), 32'(e.r));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    opa = $urandom;
    opb = $urandom;
  endtask

  initial begin
    rst = 1'b1; req = 4'd0; opa = '0; opb = '0;
    repeat (3) step();
    rst = 1'b0;
    // single operation: 0x30 + 0x30 -> 0x40
    req = 4'b0001; opa = 32'h0000_0030; opb = 32'h0000_0030;
    step();
    req = 4'd0;
    repeat (4) step();
    // all four requesting continuously
    req = 4'hF;
    for (int i = 0; i < 15; i++) begin rand_ops(); step(); end
    req = 4'd0;
    repeat (4) step();
    // withdrawal after one cycle, operands changing underneath
    req = 4'b0100; rand_ops();
    step();
    req = 4'd0;
    for (int i = 0; i < 4; i++) begin rand_ops(); step(); end
    // move ptr off zero, then abort an op for requester 2 in RESP
    req = 4'b0001; rand_ops();
    step();
    req = 4'd0;
    repeat (4) step();
    req = 4'b0100; rand_ops();
    step();
    req = 4'd0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; req = 4'hF;
    for (int i = 0; i < 12; i++) begin rand_ops(); step(); end
    req = 4'b1010;
    for (int i = 0; i < 12; i++) begin rand_ops(); step(); end
    req = 4'd0;
    repeat (4) step();
    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      req = 4'($urandom);
      rand_ops();
      rst = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    // enough back-to-back operations to wrap op_cnt
    for (int i = 0; i < 800; i++) begin
      req = 4'($urandom_range(1, 15));
      rand_ops();
      step();
    end
    req = 4'd0;
    repeat (5) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp8_add_arbiter.md
FP8_ADD_ARBITER -- requirements
Module: fp8_add_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port req, input, 4 bits: one request line per requester 0..3.
REQ-004 SHALL have port opa, input, 32 bits: requester i operand X on opa[8i+7:8i]; format {sign, exp[2:0], frac[3:0]}.
REQ-005 SHALL have port opb, input, 32 bits: requester i operand Y on opb[8i+7:8i]; same format.
REQ-006 SHALL have port gnt, output, 4 bits: one-hot grant to the requester being served.
REQ-007 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-008 SHALL have port add_x, output, 8 bits: registered X operand to the shared combinational fp8 adder.
REQ-009 SHALL have port add_y, output, 8 bits: registered Y operand to the shared adder.
REQ-010 SHALL have port add_z, input, 8 bits: shared adder sum, valid combinationally from add_x/add_y.
REQ-011 SHALL have port res, output, 8 bits: registered sum returned to the served requester.
REQ-012 SHALL have port res_vld, output, 4 bits: one-hot, one-cycle result strobe.
REQ-013 SHALL have port op_cnt, output, 8 bits: count of completed operations.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC and RESP.
REQ-015 IDLE SHALL, on an edge with req!=0, select a winner, latch its opa/opb slice into add_x/add_y, and move to EXEC; with req==0 it SHALL stay in IDLE with add_x/add_y unchanged.
REQ-016 Round-robin selection SHALL search from pointer ptr[1:0] upward, mod 4, and pick the first set req bit.
REQ-017 EXEC SHALL drive gnt one-hot for the winner for exactly one cycle, register add_z into res on the closing edge, and move to RESP.
REQ-018 RESP SHALL assert res_vld one-hot for the winner for exactly one cycle and hold res stable.
REQ-019 On the closing edge of RESP, the block SHALL set ptr to winner+1 mod 4, increment op_cnt, and return to IDLE.
REQ-020 Latency SHALL be fixed: a request sampled at edge k gives gnt high in cycle k+1 and res_vld high in cycle k+2.
REQ-021 Throughput SHALL be at most one operation per 3 cycles; no arbitration SHALL occur in EXEC or RESP.
REQ-022 Once latched, an operation SHALL complete even if req or the operands change or drop.
REQ-023 Requests arriving during EXEC or RESP SHALL be held off and considered only on the next IDLE edge.
REQ-024 A requester whose req is still high after its res_vld SHALL be treated as a new request.
REQ-025 op_cnt SHALL wrap from 0xFF to 0x00.
REQ-026 gnt and res_vld SHALL be zero outside EXEC and RESP respectively; busy SHALL be high in EXEC and RESP only.
REQ-027 The block SHALL not inspect or modify operand or result values; all arithmetic is done by the external adder.

Reset
REQ-028 On rst, state SHALL be IDLE; gnt, res_vld, busy, add_x, add_y, res and op_cnt SHALL be 0; ptr SHALL be 0.
REQ-029 rst asserted in EXEC or RESP SHALL abort the operation: no res_vld is issued, and op_cnt and ptr are not updated.
REQ-030 rst SHALL take priority over every other event on the same edge.

Configuration
REQ-031 With macro FP8_ARB_FIXED_PRIO_EN defined, selection SHALL be fixed-priority with the lowest index winning, and ptr SHALL be held at 0.
REQ-032 Without FP8_ARB_FIXED_PRIO_EN, selection SHALL be round-robin per REQ-016 and REQ-019.

Verification
REQ-033 Single op: req=0001, opa[7:0]=0x30, opb[7:0]=0x30, with the bench adder model in place -> gnt=0001 in cycle k+1; res=0x40 and res_vld=0001 in cycle k+2; op_cnt=1.
REQ-034 Round-robin, all four requesting continuously from reset -> grant order 0,1,2,3,0; one res_vld every 3 cycles.
REQ-035 Fixed-priority build (FP8_ARB_FIXED_PRIO_EN defined), req=1010 held -> requester 1 wins every operation and requester 3 never wins.
REQ-036 rst asserted during RESP of an op for requester 2 -> res_vld stays 0000, op_cnt is unchanged, and the next grant follows ptr=0 ordering.
REQ-037 Withdrawal and wrap: req=0100 for one cycle only -> operation still completes with res_vld=0100; separately, 256 operations -> op_cnt returns to 0x00.
